// File: rtl/inst_rom_arbiter_pkg.sv
// inst_rom_arbiter_pkg: chip-enable levels and grant encoding shared by the instruction ROM arbiter
package inst_rom_arbiter_pkg;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DBG} gnt_e;
endpackage

// File: rtl/inst_rom_arbiter_if.sv
// inst_rom_arbiter_if: IF and DBG request/response channels plus the shared ROM port
interface inst_rom_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic if_req;
  logic [ADDR_W-1:0] if_addr;
  logic if_gnt;
  logic if_valid;
  logic [DATA_W-1:0] if_inst;
  logic if_err;
  logic dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic dbg_gnt;
  logic dbg_valid;
  logic [DATA_W-1:0] dbg_inst;
  logic dbg_err;
  logic rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  modport slave (
    input if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    output if_gnt, if_valid, if_inst, if_err, dbg_gnt, dbg_valid, dbg_inst, dbg_err, rom_ce, rom_addr
  );
  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, rom_inst,
    input if_gnt, if_valid, if_inst, if_err, dbg_gnt, dbg_valid, dbg_inst, dbg_err, rom_ce, rom_addr
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating DBG wait counter forcing a DBG grant after MAX_WAIT stalls (built only with ARB_STARVE_GUARD_EN)
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt #(parameter int MAX_WAIT = 4) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic dbg_force
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  assign dbg_force = dbg_req && cnt == CW'(MAX_WAIT);
  // Count stalled DBG cycles up to MAX_WAIT; clear on a grant or when DBG backs off
  always_ff @(posedge clk)
    cnt <= (rst || !dbg_req || dbg_gnt) ? '0 : (cnt == CW'(MAX_WAIT)) ? cnt : cnt + 1'b1;
endmodule
`endif

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: IF > DBG arbiter for the instruction ROM with 1-cycle registered responses; ARB_STARVE_GUARD_EN adds DBG anti-starvation
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = 131071,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  inst_rom_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= MEM_LIMIT);
  endfunction
  gnt_e sel;
  logic dbg_force, if_bad, dbg_bad, win_bad, ce;
  logic [ADDR_W-1:0] win_addr;
`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .dbg_req(bus.dbg_req),
    .dbg_gnt(bus.dbg_gnt),
    .dbg_force(dbg_force)
  );
`else
  assign dbg_force = MAX_WAIT < 0;
`endif
  // Pick the winner (DBG only when IF is idle or the guard fires) and drive the ROM port
  always_comb begin
    if_bad = addr_err(bus.if_addr);
    dbg_bad = addr_err(bus.dbg_addr);
    sel = rst ? GNT_NONE : (bus.dbg_req && (!bus.if_req || dbg_force)) ? GNT_DBG : bus.if_req ? GNT_IF : GNT_NONE;
    win_addr = sel == GNT_DBG ? bus.dbg_addr : bus.if_addr;
    win_bad = sel == GNT_DBG ? dbg_bad : if_bad;
    ce = sel != GNT_NONE && !win_bad;
    bus.if_gnt = sel == GNT_IF;
    bus.dbg_gnt = sel == GNT_DBG;
    bus.rom_ce = ce ? CHIP_ENABLE : CHIP_DISABLE;
    bus.rom_addr = ce ? win_addr : '0;
  end
  // Register the winner's response one cycle after its grant; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.if_valid <= 1'b0;
      bus.if_err <= 1'b0;
      bus.if_inst <= '0;
      bus.dbg_valid <= 1'b0;
      bus.dbg_err <= 1'b0;
      bus.dbg_inst <= '0;
    end else begin
      bus.if_valid <= sel == GNT_IF;
      bus.if_err <= sel == GNT_IF && if_bad;
      bus.if_inst <= (sel == GNT_IF && !if_bad) ? bus.rom_inst : '0;
      bus.dbg_valid <= sel == GNT_DBG;
      bus.dbg_err <= sel == GNT_DBG && dbg_bad;
      bus.dbg_inst <= (sel == GNT_DBG && !dbg_bad) ? bus.rom_inst : '0;
    end
  end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: table-driven check of grants, ROM port and registered responses of inst_rom_arbiter
module tb_inst_rom_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(131071), .MAX_WAIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [31:0] mem [0:63];
  assign bus.rom_inst = mem[bus.rom_addr[7:2]];
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  typedef struct {
    logic rst, ir;
    logic [31:0] ia;
    logic dr;
    logic [31:0] da;
    logic ig, dg, ce;
    logic [31:0] ra;
    logic iv;
    logic [31:0] ii;
    logic ie, dv;
    logic [31:0] di;
    logic de;
  } vec_t;
  vec_t vt [0:13];
  int vectors = 0;
  int miscompares = 0;
  int cur = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %h expected %h", cur, name, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst;
    bus.if_req = v.ir;
    bus.if_addr = v.ia;
    bus.dbg_req = v.dr;
    bus.dbg_addr = v.da;
    #1;
    chk("if_gnt", 32'(bus.if_gnt), 32'(v.ig));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(v.dg));
    chk("rom_ce", 32'(bus.rom_ce), 32'(v.ce));
    if (v.ce || !(v.ig || v.dg)) chk("rom_addr", bus.rom_addr, v.ra);
    @(posedge clk);
    #1;
    chk("if_valid", 32'(bus.if_valid), 32'(v.iv));
    chk("if_err", 32'(bus.if_err), 32'(v.ie));
    chk("dbg_valid", 32'(bus.dbg_valid), 32'(v.dv));
    chk("dbg_err", 32'(bus.dbg_err), 32'(v.de));
    if (v.iv || v.rst) chk("if_inst", bus.if_inst, v.ii);
    if (v.dv || v.rst) chk("dbg_inst", bus.dbg_inst, v.di);
    vectors++;
    cur++;
  endtask
  initial begin
    vec_t c;
    bit g;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[0] = 32'h34011100;
    mem[1] = 32'h34020020;
    mem[2] = 32'h3403ff00;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h10;
    vt[0] = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[1] = vt[0];
    vt[2] = vt[0];
    vt[3] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h34011100, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h34020020, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h3403ff00, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0DE0004, 1'b0};
    vt[8] = '{1'b0, 1'b1, 32'h6, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vt[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h7FFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h7FFF8, 1'b0, 1'b1, 1'b1, 32'h7FFF8, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0DE003E, 1'b0};
    vt[11] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'hC0DE0003, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[13] = vt[5];
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) apply(vt[i]);
    apply(vt[6]);
    for (int k = 1; k <= 6; k++) begin
      g = GUARD && k == 5;
      c = '{1'b0, 1'b1, 32'h0, 1'b1, 32'h10, !g, g, 1'b1, g ? 32'h10 : 32'h0,
            !g, g ? 32'h0 : 32'h34011100, 1'b0, g, g ? 32'hC0DE0004 : 32'h0, 1'b0};
      apply(c);
    end
    apply(vt[6]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
